// File: rtl/i2s_receiver_pkg.sv
// Shared types and constants for the I2S ADC receiver.
package i2s_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RECV = 2'd2
    } rx_state_e;

    localparam int OVR_CNT_W = 8;

endpackage

// File: rtl/i2s_receiver_if.sv
// Sample-pair stream with overrun status, receiver (master) to consumer (slave).
interface i2s_receiver_if #(
    parameter int DATA_BITS = 16
);
    import i2s_receiver_pkg::*;

    logic [DATA_BITS-1:0] data_l;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid;
    logic                 ready;
    logic                 overrun;
    logic [OVR_CNT_W-1:0] overrun_cnt;
    logic                 overrun_clr;

    modport master (output data_l, data_r, valid, overrun, overrun_cnt,
                    input  ready, overrun_clr);
    modport slave  (input  data_l, data_r, valid, overrun, overrun_cnt,
                    output ready, overrun_clr);
endinterface

// File: rtl/i2s_receiver_sync_2ff.sv
// Two-flop synchronizer for one asynchronous codec pin.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/i2s_receiver.sv
// I2S ADC receiver: oversamples BCLK/LRCK/DAT in clk, assembles R then L into a pair.
// Optional overrun flag/counter enabled by defining I2S_RX_OVERRUN_EN.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int LEADING_BITS = 1,
    parameter int DATA_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 codec_aud_bclk_i,
    input  logic                 codec_aud_adclrck_i,
    input  logic                 codec_aud_adcdat_i,
    input  logic                 i2s_enable_i,
    output logic [DATA_BITS-1:0] i2s_sample_data_L_o,
    output logic [DATA_BITS-1:0] i2s_sample_data_R_o,
    output logic                 i2s_valid_o,
    input  logic                 i2s_ready_i,
    output logic                 i2s_overrun_o,
    output logic [OVR_CNT_W-1:0] i2s_overrun_cnt_o,
    input  logic                 i2s_overrun_clr_i
);
    localparam int CNT_W = $clog2(LEADING_BITS + DATA_BITS + 1);
    localparam logic [CNT_W-1:0] FIRST_IDX = CNT_W'(LEADING_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(LEADING_BITS + DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic bclk_s, lrck_s, dat_s;

    sync_2ff u_sync_bclk (.clk(clk), .rst_n(rst_n), .d_i(codec_aud_bclk_i),    .q_o(bclk_s));
    sync_2ff u_sync_lrck (.clk(clk), .rst_n(rst_n), .d_i(codec_aud_adclrck_i), .q_o(lrck_s));
    sync_2ff u_sync_dat  (.clk(clk), .rst_n(rst_n), .d_i(codec_aud_adcdat_i),  .q_o(dat_s));

    rx_state_e            state_q;
    logic                 bclk_hist_q, lrck_prev_q, r_ok_q, valid_q;
    logic [CNT_W-1:0]     bit_cnt_q, idx_d;
    logic [DATA_BITS-2:0] shift_q;
    logic [DATA_BITS-1:0] shift_d, r_hold_q, data_l_q, data_r_q;
    logic                 strobe, lrck_edge, pair_done;

    // idx_d is the half-frame bit index of the bit being sampled on this strobe
    always_comb begin
        strobe    = bclk_s & ~bclk_hist_q;
        lrck_edge = lrck_s ^ lrck_prev_q;
        idx_d     = lrck_edge ? '0 :
                    (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + CNT_W'(1);
        shift_d   = {shift_q, dat_s};
        pair_done = strobe && (state_q == RECV) && i2s_enable_i &&
                    (idx_d == LAST_IDX) && lrck_s && r_ok_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bclk_hist_q <= 1'b0;
            lrck_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            r_ok_q      <= 1'b0;
            shift_q     <= '0;
            r_hold_q    <= '0;
            data_l_q    <= '0;
            data_r_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            bclk_hist_q <= bclk_s;
            if (strobe) lrck_prev_q <= lrck_s;

            if (!i2s_enable_i) begin
                state_q   <= IDLE;
                bit_cnt_q <= '0;
                r_ok_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= SYNC;
                    SYNC: if (strobe && lrck_prev_q && !lrck_s) begin
                        state_q   <= RECV;
                        bit_cnt_q <= '0;
                        r_ok_q    <= 1'b0;
                        if (FIRST_IDX == '0) shift_q <= shift_d[DATA_BITS-2:0];
                    end
                    RECV: if (strobe) begin
                        bit_cnt_q <= idx_d;
                        // half ended before its last data bit: frame is unusable
                        if (lrck_edge && bit_cnt_q < LAST_IDX) r_ok_q <= 1'b0;
                        if (idx_d >= FIRST_IDX && idx_d <= LAST_IDX)
                            shift_q <= shift_d[DATA_BITS-2:0];
                        if (idx_d == LAST_IDX) begin
                            if (!lrck_s) begin
                                r_hold_q <= shift_d;
                                r_ok_q   <= 1'b1;
                            end else begin
                                r_ok_q   <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // a new pair may replace the presented one only in the accept cycle
            if (pair_done && (!valid_q || i2s_ready_i)) begin
                valid_q  <= 1'b1;
                data_l_q <= shift_d;
                data_r_q <= r_hold_q;
            end else if (i2s_ready_i) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign i2s_valid_o         = valid_q;
    assign i2s_sample_data_L_o = data_l_q;
    assign i2s_sample_data_R_o = data_r_q;

`ifdef I2S_RX_OVERRUN_EN
    logic                 drop, ovr_q;
    logic [OVR_CNT_W-1:0] ovr_cnt_q;

    assign drop = pair_done & valid_q & ~i2s_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q     <= 1'b0;
            ovr_cnt_q <= '0;
        end else if (i2s_overrun_clr_i) begin
            ovr_q     <= drop;
            ovr_cnt_q <= drop ? OVR_CNT_W'(1) : '0;
        end else if (drop) begin
            ovr_q <= 1'b1;
            if (ovr_cnt_q != '1) ovr_cnt_q <= ovr_cnt_q + OVR_CNT_W'(1);
        end
    end

    assign i2s_overrun_o     = ovr_q;
    assign i2s_overrun_cnt_o = ovr_cnt_q;
`else
    logic unused_ovr_clr;
    assign unused_ovr_clr    = i2s_overrun_clr_i;
    assign i2s_overrun_o     = 1'b0;
    assign i2s_overrun_cnt_o = '0;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver; overrun expectations follow I2S_RX_OVERRUN_EN.
module tb_i2s_receiver;
    import i2s_receiver_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic bclk = 1'b0, lrck = 1'b1, adcdat = 1'b0, en = 1'b0;
    logic vld_prev = 1'b0;
    int   errors = 0, checks = 0, rises = 0;

    i2s_receiver_if #(.DATA_BITS(16)) bus ();

    always #5 clk = ~clk;

    i2s_receiver #(.LEADING_BITS(1), .DATA_BITS(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .codec_aud_bclk_i    (bclk),
        .codec_aud_adclrck_i (lrck),
        .codec_aud_adcdat_i  (adcdat),
        .i2s_enable_i        (en),
        .i2s_sample_data_L_o (bus.data_l),
        .i2s_sample_data_R_o (bus.data_r),
        .i2s_valid_o         (bus.valid),
        .i2s_ready_i         (bus.ready),
        .i2s_overrun_o       (bus.overrun),
        .i2s_overrun_cnt_o   (bus.overrun_cnt),
        .i2s_overrun_clr_i   (bus.overrun_clr)
    );

    always @(posedge clk) begin
        vld_prev <= bus.valid;
        if (bus.valid && !vld_prev) rises <= rises + 1;
    end

`ifdef I2S_RX_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    // One BCLK period: low hp clks (data/lrck change), high hp clks.
    // v2/v3: valid seen 2 and 3 negedges after the rising edge (hp=4 only).
    task automatic send_bit(input logic lr, input logic d, input int hp, input logic clr_pulse,
                            output logic v2, output logic v3);
        v2 = 1'b0; v3 = 1'b0;
        @(negedge clk); bclk = 1'b0; lrck = lr; adcdat = d;
        repeat (hp) @(negedge clk);
        bclk = 1'b1;
        for (int k = 1; k < hp; k++) begin
            @(negedge clk);
            if (k == 2) begin v2 = bus.valid; if (clr_pulse) bus.overrun_clr = 1'b1; end
            if (k == 3) begin v3 = bus.valid; bus.overrun_clr = 1'b0; end
        end
    endtask

    // slot 0 dummy, slots 1..16 data MSB first, later slots filler 1s
    task automatic send_half(input logic lr, input logic [15:0] d, input int nslots, input int hp,
                             input logic clr_pulse, output logic v_pre, output logic v_post);
        logic a, b, bitv;
        v_pre = 1'b0; v_post = 1'b0;
        for (int s = 0; s < nslots; s++) begin
            bitv = (s >= 1 && s <= 16) ? d[16-s] : 1'b1;
            send_bit(lr, bitv, hp, clr_pulse && (s == 16), a, b);
            if (s == 16) begin v_pre = a; v_post = b; end
        end
    endtask

    task automatic send_frame(input logic [15:0] r, input logic [15:0] l, input int nslots,
                              input int hp, input logic clr_pulse, output logic v_pre, output logic v_post);
        logic a, b;
        send_half(1'b0, r, nslots, hp, 1'b0, a, b);
        send_half(1'b1, l, nslots, hp, clr_pulse, v_pre, v_post);
    endtask

    task automatic drain();
        bus.ready = 1'b1; @(negedge clk); bus.ready = 1'b0;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.valid); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; repeat (3) @(negedge clk);
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (bus.data_l !== 16'h0) begin errors++; $display("FAIL reset_L: got %h want 0000", bus.data_l); end
        checks++; if (bus.data_r !== 16'h0) begin errors++; $display("FAIL reset_R: got %h want 0000", bus.data_r); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
        checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.overrun_cnt); end
        rst_n = 1'b1; @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic pre, post; int r0;
        en = 1'b1;
        send_half(1'b1, 16'hFFFF, 18, 4, 1'b0, pre, post);
        r0 = rises;
        send_half(1'b0, 16'hA5C3, 18, 4, 1'b0, pre, post);
        send_half(1'b1, 16'h1234, 18, 4, 1'b0, pre, post);
        checks++; if (pre !== 1'b0) begin errors++; $display("FAIL basic_valid_strobe_cycle: got %b want 0", pre); end
        checks++; if (post !== 1'b1) begin errors++; $display("FAIL basic_valid_next_clk: got %b want 1", post); end
        checks++; if (bus.data_l !== 16'h1234) begin errors++; $display("FAIL basic_L: got %h want 1234", bus.data_l); end
        checks++; if (bus.data_r !== 16'hA5C3) begin errors++; $display("FAIL basic_R: got %h want a5c3", bus.data_r); end
        checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", rises - r0); end
        drain();
    endtask

    task automatic test_backpressure();
        logic pre, post;
        send_frame(16'h1111, 16'h2222, 18, 4, 1'b0, pre, post);
        send_frame(16'h3333, 16'h4444, 18, 4, 1'b0, pre, post);
        send_frame(16'h5555, 16'h6666, 18, 4, 1'b0, pre, post);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", bus.valid); end
        checks++; if (bus.data_l !== 16'h2222) begin errors++; $display("FAIL bp_L: got %h want 2222", bus.data_l); end
        checks++; if (bus.data_r !== 16'h1111) begin errors++; $display("FAIL bp_R: got %h want 1111", bus.data_r); end
        checks++; if (bus.overrun !== OVR) begin errors++; $display("FAIL bp_ovr: got %b want %b", bus.overrun, OVR); end
        checks++; if (bus.overrun_cnt !== (OVR ? 8'd2 : 8'd0)) begin errors++; $display("FAIL bp_cnt: got %0d want %0d", bus.overrun_cnt, OVR ? 2 : 0); end
        bus.overrun_clr = 1'b1; @(negedge clk); bus.overrun_clr = 1'b0;
        checks++; if (bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL bp_clr_cnt: got %0d want 0", bus.overrun_cnt); end
        drain();
    endtask

    task automatic test_enable_mid();
        logic pre, post; int r0;
        en = 1'b0;
        send_half(1'b0, 16'hAAAA, 18, 4, 1'b0, pre, post);
        send_half(1'b1, 16'hFFFF, 8, 4, 1'b0, pre, post);
        en = 1'b1;
        r0 = rises;
        send_half(1'b1, 16'hFFFF, 10, 4, 1'b0, pre, post);
        send_half(1'b0, 16'h0F0F, 18, 4, 1'b0, pre, post);
        checks++; if (rises !== r0 || bus.valid !== 1'b0) begin errors++; $display("FAIL en_mid_early: valid %b rises %0d want 0 0", bus.valid, rises - r0); end
        send_half(1'b1, 16'hF0F0, 18, 4, 1'b0, pre, post);
        checks++; if (post !== 1'b1) begin errors++; $display("FAIL en_mid_valid: got %b want 1", post); end
        checks++; if (bus.data_l !== 16'hF0F0 || bus.data_r !== 16'h0F0F) begin errors++; $display("FAIL en_mid_pair: got %h/%h want f0f0/0f0f", bus.data_l, bus.data_r); end
        en = 1'b0; repeat (5) @(negedge clk);
        checks++; if (bus.valid !== 1'b1 || bus.data_l !== 16'hF0F0) begin errors++; $display("FAIL en_fall_hold: got %b/%h want 1/f0f0", bus.valid, bus.data_l); end
        drain();
        en = 1'b1;
    endtask

    task automatic test_short_half();
        logic pre, post; int r0;
        r0 = rises;
        send_half(1'b0, 16'hDEAD, 11, 4, 1'b0, pre, post);
        send_half(1'b1, 16'hBEEF, 18, 4, 1'b0, pre, post);
        checks++; if (rises !== r0 || bus.valid !== 1'b0) begin errors++; $display("FAIL short_no_pair: valid %b rises %0d want 0 0", bus.valid, rises - r0); end
        send_frame(16'h1357, 16'h2468, 18, 4, 1'b0, pre, post);
        checks++; if (post !== 1'b1 || bus.data_l !== 16'h2468 || bus.data_r !== 16'h1357) begin errors++; $display("FAIL short_next: got %b %h/%h want 1 2468/1357", post, bus.data_l, bus.data_r); end
        drain();
    endtask

    task automatic test_reset_mid();
        logic pre, post;
        send_frame(16'h0A0A, 16'h5050, 18, 4, 1'b0, pre, post);
        send_half(1'b0, 16'h7777, 18, 4, 1'b0, pre, post);
        send_half(1'b1, 16'h8888, 8, 4, 1'b0, pre, post);
        checks++; if (bus.valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid: got %b want 1", bus.valid); end
        rst_n = 1'b0; #1;
        checks++; if (bus.valid !== 1'b0 || bus.data_l !== 16'h0 || bus.data_r !== 16'h0) begin errors++; $display("FAIL rmid_outputs: got %b %h/%h want 0 0000/0000", bus.valid, bus.data_l, bus.data_r); end
        checks++; if (bus.overrun !== 1'b0 || bus.overrun_cnt !== 8'd0) begin errors++; $display("FAIL rmid_ovr: got %b/%0d want 0/0", bus.overrun, bus.overrun_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send_half(1'b1, 16'h8888, 10, 4, 1'b0, pre, post);
        send_frame(16'h0C0C, 16'h3030, 18, 4, 1'b0, pre, post);
        checks++; if (post !== 1'b1 || bus.data_l !== 16'h3030 || bus.data_r !== 16'h0C0C) begin errors++; $display("FAIL rmid_resume: got %b %h/%h want 1 3030/0c0c", post, bus.data_l, bus.data_r); end
        drain();
    endtask

    task automatic test_overrun_sat();
        logic pre, post;
        bus.overrun_clr = 1'b1; @(negedge clk); bus.overrun_clr = 1'b0;
        send_frame(16'h0001, 16'h0002, 17, 2, 1'b0, pre, post);
        for (int i = 0; i < 300; i++) send_frame(16'h00F0, 16'h0F00, 17, 2, 1'b0, pre, post);
        checks++; if (bus.overrun_cnt !== 8'd255 || bus.overrun !== 1'b1) begin errors++; $display("FAIL sat_cnt: got %0d/%b want 255/1", bus.overrun_cnt, bus.overrun); end
        checks++; if (bus.valid !== 1'b1 || bus.data_l !== 16'h0002 || bus.data_r !== 16'h0001) begin errors++; $display("FAIL sat_hold: got %b %h/%h want 1 0002/0001", bus.valid, bus.data_l, bus.data_r); end
        send_frame(16'h00F0, 16'h0F00, 18, 4, 1'b1, pre, post);
        checks++; if (bus.overrun !== 1'b1 || bus.overrun_cnt !== 8'd1) begin errors++; $display("FAIL clr_with_drop: got %b/%0d want 1/1", bus.overrun, bus.overrun_cnt); end
        drain();
    endtask

    initial begin
        bus.ready = 1'b0;
        bus.overrun_clr = 1'b0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_enable_mid();
        test_short_half();
        test_reset_mid();
        if (OVR) test_overrun_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
